// File: rtl/microcode_ahb_if_if.sv
// AHB-Lite bus bundle for the microcode front end.
// The master drives the address/data phases; the slave returns ready, response and read data.
interface microcode_ahb_if_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;

  modport master (
    output HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/microcode_ahb_if.sv
// AHB-Lite slave holding the microcode store plus the START/END/CTRL registers for the sequencer.
// Zero wait states; the sequencer reads the store combinationally at uc_addr.
module microcode_ahb_if #(
  parameter int UC_DEPTH = 256,  // must equal 2**UC_AW
  parameter int UC_AW    = 8     // at most 8: the RAM window is fixed at 1 KiB
) (
  input  logic              clk,
  input  logic              RST,
  microcode_ahb_if_if.slave ahb,
  output logic [UC_AW-1:0]  s_addr,
  output logic [UC_AW-1:0]  e_addr,
  output logic              ena,
  input  logic [UC_AW-1:0]  uc_addr,
  output logic [31:0]       MicroCode,
  input  logic [7:0]        indata
);

  typedef struct packed {
    logic       wr;
    logic [9:0] widx;  // HADDR[11:2]
    logic [3:0] be;
  } dphase_t;

  localparam logic [9:0] W_CTRL  = 10'h100;
  localparam logic [9:0] W_START = 10'h101;
  localparam logic [9:0] W_END   = 10'h102;
  localparam logic [9:0] W_STAT  = 10'h103;

  function automatic logic [3:0] lane_strobe(input logic [2:0] size, input logic [1:0] a);
    case (size)
      3'd0:    lane_strobe = 4'b0001 << a;
      3'd1:    lane_strobe = a[1] ? 4'b1100 : 4'b0011;
      default: lane_strobe = 4'b1111;
    endcase
  endfunction

  dphase_t          dp_d, dp_q;
  logic             dp_vld_d, dp_vld_q;
  logic             ena_d, ena_q;
  logic [UC_AW-1:0] s_d, s_q;
  logic [UC_AW-1:0] e_d, e_q;

  logic             accept;
  logic             is_ram, is_ctrl, is_start, is_end, is_stat;
  logic             commit, ram_we, reg_we;
  logic [UC_AW-1:0] ram_idx;
  logic [31:0]      ram_rd;
  logic [31:0]      rdata_c;
  logic             unused_ok;

  assign unused_ok = ^{ahb.HADDR[31:12], ahb.HTRANS[0]};

  // Address phase capture; held while another slave stretches the bus.
  always_comb begin
    accept   = ahb.HSEL & ahb.HREADY & ahb.HTRANS[1];
    dp_vld_d = dp_vld_q;
    dp_d     = dp_q;
    if (ahb.HREADY) begin
      dp_vld_d = accept;
      dp_d.wr   = ahb.HWRITE;
      dp_d.widx = ahb.HADDR[11:2];
      dp_d.be   = lane_strobe(ahb.HSIZE, ahb.HADDR[1:0]);
    end
  end

  always_comb begin
    is_ram   = (dp_q.widx[9:8] == 2'b00);
    is_ctrl  = (dp_q.widx == W_CTRL);
    is_start = (dp_q.widx == W_START);
    is_end   = (dp_q.widx == W_END);
    is_stat  = (dp_q.widx == W_STAT);
    ram_idx  = dp_q.widx[UC_AW-1:0];
  end

  // Writes land at the edge closing the data phase. ena_q is the value before
  // this commit, so a CTRL write does not protect its own data phase.
  always_comb begin
    commit = dp_vld_q & dp_q.wr & ahb.HREADY;
    ram_we = commit & is_ram & ~ena_q;
    reg_we = commit & dp_q.be[0];
    ena_d  = ena_q;
    s_d    = s_q;
    e_d    = e_q;
    if (reg_we & is_ctrl)           ena_d = ahb.HWDATA[0];
    if (reg_we & is_start & ~ena_q) s_d   = ahb.HWDATA[UC_AW-1:0];
    if (reg_we & is_end & ~ena_q)   e_d   = ahb.HWDATA[UC_AW-1:0];
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      dp_vld_q <= 1'b0;
      dp_q     <= '0;
      ena_q    <= 1'b0;
      s_q      <= '0;
      e_q      <= '0;
    end else begin
      dp_vld_q <= dp_vld_d;
      dp_q     <= dp_d;
      ena_q    <= ena_d;
      s_q      <= s_d;
      e_q      <= e_d;
    end
  end

  // One byte-wide bank per lane; two async read ports (bus and sequencer).
  for (genvar g = 0; g < 4; g++) begin : g_lane
    logic [7:0] bank_q [UC_DEPTH];

    always_ff @(posedge clk) begin
      if (ram_we && dp_q.be[g]) bank_q[ram_idx] <= ahb.HWDATA[8*g +: 8];
    end

    assign ram_rd[8*g +: 8]    = bank_q[ram_idx];
    assign MicroCode[8*g +: 8] = bank_q[uc_addr];
  end

  always_comb begin
    rdata_c = '0;
    if (dp_vld_q && !dp_q.wr) begin
      if (is_ram)        rdata_c = ram_rd;
      else if (is_ctrl)  rdata_c[0] = ena_q;
      else if (is_start) rdata_c[UC_AW-1:0] = s_q;
      else if (is_end)   rdata_c[UC_AW-1:0] = e_q;
      else if (is_stat) begin
        rdata_c[7:0] = indata;
        rdata_c[8]   = ena_q;
      end
    end
  end

  assign ahb.HRDATA    = rdata_c;
  assign ahb.HREADYOUT = 1'b1;
  assign ahb.HRESP     = 1'b0;

  assign s_addr = s_q;
  assign e_addr = e_q;
  assign ena    = ena_q;

endmodule

// File: tb/tb_microcode_ahb_if.sv
// Randomized scoreboard bench for microcode_ahb_if: transfers are scored against an
// in-order transaction model; a negedge monitor checks read data and sequencer outputs.
module tb_microcode_ahb_if;
  logic        clk = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  s_addr, e_addr, uc_addr, indata;
  logic        ena;
  logic [31:0] MicroCode;

  always #5 clk = ~clk;

  microcode_ahb_if_if bus();

  microcode_ahb_if #(.UC_DEPTH(256), .UC_AW(8)) dut (
    .clk(clk), .RST(RST), .ahb(bus),
    .s_addr(s_addr), .e_addr(e_addr), .ena(ena),
    .uc_addr(uc_addr), .MicroCode(MicroCode), .indata(indata)
  );

  typedef struct {
    bit          rd;
    bit          rd_chk;
    logic [31:0] rdata;
    bit          ram_w;
    logic [7:0]  idx;
    logic [31:0] word;
    logic [7:0]  s, e;
    bit          en;
  } item_t;

  item_t sbq[$];
  int vecs = 0, errs = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: transactions take effect in issue order.
  logic [31:0] m_mem [256];
  bit          m_known [256];
  bit          m_ena;
  logic [7:0]  m_s, m_e;
  logic [31:0] pend_wd = '0;
  bit          uc_hold = 1'b0;

  task automatic xfer(bit wr, logic [31:0] addr, logic [2:0] size, logic [31:0] wdata);
    item_t       it;
    logic [3:0]  be;
    int          a;
    int          idx;
    logic [31:0] hi;
    a = int'(addr[11:0]);
    case (size)
      3'd0:    be = 4'b0001 << addr[1:0];
      3'd1:    be = addr[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    it = '{default: 0};
    it.rd = !wr;
    it.rd_chk = 1'b1;
    it.rdata = 32'h0;
    if (a < 'h400) begin
      idx = a / 4;
      if (wr && !m_ena) begin
        for (int l = 0; l < 4; l++)
          if (be[l]) m_mem[idx][8*l +: 8] = wdata[8*l +: 8];
        if (be == 4'hf) m_known[idx] = 1'b1;
        it.ram_w = m_known[idx];
        it.idx   = 8'(idx);
        it.word  = m_mem[idx];
      end
      if (!wr) begin
        it.rd_chk = m_known[idx];
        it.rdata  = m_mem[idx];
      end
    end else if (a == 'h400) begin
      if (wr && be[0]) m_ena = wdata[0];
      it.rdata = {31'h0, m_ena};
    end else if (a == 'h404) begin
      if (wr && be[0] && !m_ena) m_s = wdata[7:0];
      it.rdata = {24'h0, m_s};
    end else if (a == 'h408) begin
      if (wr && be[0] && !m_ena) m_e = wdata[7:0];
      it.rdata = {24'h0, m_e};
    end else if (a == 'h40C) begin
      it.rdata = {23'h0, m_ena, indata};
    end
    it.s = m_s; it.e = m_e; it.en = m_ena;
    sbq.push_back(it);
    hi = $urandom;
    bus.HSEL   = 1'b1;
    bus.HTRANS = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b10;
    bus.HADDR  = {hi[31:12], addr[11:0]};
    bus.HSIZE  = size;
    bus.HWRITE = wr;
    bus.HWDATA = pend_wd;
    pend_wd    = wr ? wdata : $urandom;
    if (!uc_hold) uc_addr = 8'($urandom);
    @(posedge clk); #1;
  endtask

  task automatic idle();
    bus.HSEL   = 1'($urandom_range(0, 1));
    bus.HTRANS = bus.HSEL ? 2'($urandom_range(0, 1)) : 2'($urandom_range(0, 3));
    bus.HADDR  = $urandom;
    bus.HWRITE = 1'($urandom_range(0, 1));
    bus.HSIZE  = 3'd2;
    bus.HWDATA = pend_wd;
    pend_wd    = $urandom;
    if (!uc_hold) uc_addr = 8'($urandom);
    @(posedge clk); #1;
  endtask

  // Monitor: state committed by popped transfers, applied one edge after their data phase.
  bit          mon_en = 1'b0;
  bit          acc_prev = 1'b0;
  bit          pend_v = 1'b0;
  item_t       pend, cur;
  logic [31:0] cmem [256];
  bit          c_known [256];
  logic [7:0]  c_s = '0, c_e = '0;
  bit          c_ena = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (pend_v) begin
        c_s = pend.s; c_e = pend.e; c_ena = pend.en;
        if (pend.ram_w) begin
          cmem[pend.idx]    = pend.word;
          c_known[pend.idx] = 1'b1;
        end
        pend_v = 1'b0;
      end
      chk("s_addr", {24'h0, s_addr}, {24'h0, c_s});
      chk("e_addr", {24'h0, e_addr}, {24'h0, c_e});
      chk("ena", {31'h0, ena}, {31'h0, c_ena});
      if (c_known[uc_addr]) chk("MicroCode", MicroCode, cmem[uc_addr]);
      if (acc_prev) begin
        if (sbq.size() == 0) begin
          vecs++; errs++;
          $display("FAIL sb_underflow: data phase with no queued transfer at %0t", $time);
        end else begin
          cur = sbq.pop_front();
          if (cur.rd && cur.rd_chk) chk("HRDATA", bus.HRDATA, cur.rdata);
          pend = cur; pend_v = 1'b1;
        end
      end else begin
        chk("HRDATA_idle", bus.HRDATA, 32'h0);
      end
      acc_prev = bus.HSEL & bus.HREADY & bus.HTRANS[1];
    end
  end

  initial begin
    logic [31:0] addr, wd;
    logic [2:0]  size;
    int          sel;
    bus.HSEL = 0; bus.HTRANS = 0; bus.HREADY = 1; bus.HADDR = 0;
    bus.HSIZE = 3'd2; bus.HWRITE = 0; bus.HWDATA = 0;
    indata = 8'h3C; uc_addr = 8'h0;
    repeat (2) @(posedge clk);
    #3 RST = 1'b0;
    @(posedge clk); #1;

    // Raw pipeline: START=0x21, CTRL=1, read START; reset lands mid read data phase.
    bus.HSEL = 1; bus.HTRANS = 2'b10; bus.HWRITE = 1; bus.HADDR = 32'h404;
    @(posedge clk); #1;
    bus.HWDATA = 32'h21; bus.HADDR = 32'h400;
    @(posedge clk); #1;
    bus.HWDATA = 32'h1; bus.HWRITE = 0; bus.HADDR = 32'h404;
    @(posedge clk); #1;
    bus.HTRANS = 2'b00;
    chk("pre_rst_s_addr", {24'h0, s_addr}, 32'h21);
    chk("pre_rst_ena", {31'h0, ena}, 32'h1);
    chk("pre_rst_HRDATA", bus.HRDATA, 32'h21);
    #3 RST = 1'b1;
    #1;
    chk("rst_ena", {31'h0, ena}, 32'h0);
    chk("rst_s_addr", {24'h0, s_addr}, 32'h0);
    chk("rst_e_addr", {24'h0, e_addr}, 32'h0);
    chk("rst_HRDATA", bus.HRDATA, 32'h0);
    chk("rst_HREADYOUT", {31'h0, bus.HREADYOUT}, 32'h1);
    chk("rst_HRESP", {31'h0, bus.HRESP}, 32'h0);
    @(posedge clk); #3 RST = 1'b0;
    @(posedge clk); #1;

    // Pending START write killed by a reset pulse inside its data phase.
    bus.HTRANS = 2'b10; bus.HWRITE = 1; bus.HADDR = 32'h404;
    @(posedge clk); #1;
    bus.HTRANS = 2'b00; bus.HWDATA = 32'h33;
    #2 RST = 1'b1;
    #2 RST = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_discard_s_addr", {24'h0, s_addr}, 32'h0);

    m_ena = 0; m_s = '0; m_e = '0;
    for (int i = 0; i < 256; i++) m_known[i] = 1'b0;
    for (int i = 0; i < 256; i++) c_known[i] = 1'b0;
    pend_wd = '0;
    mon_en = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 256; i++) xfer(1, 32'(i * 4), 3'd2, $urandom);

    uc_hold = 1'b1; uc_addr = 8'd4;
    xfer(1, 32'h010, 3'd2, 32'h12345678);
    xfer(0, 32'h010, 3'd2, 32'h0);
    xfer(1, 32'h020, 3'd2, 32'hFFFFFFFF);
    xfer(1, 32'h022, 3'd0, 32'h00AB0000);
    xfer(0, 32'h020, 3'd2, 32'h0);
    xfer(1, 32'h404, 3'd2, 32'h05);
    xfer(1, 32'h408, 3'd2, 32'h0A);
    xfer(1, 32'h400, 3'd2, 32'h1);
    xfer(0, 32'h40C, 3'd2, 32'h0);
    uc_addr = 8'd0;
    xfer(1, 32'h000, 3'd2, 32'hDEADBEEF);
    xfer(1, 32'h404, 3'd2, 32'h77);
    xfer(0, 32'h000, 3'd2, 32'h0);
    xfer(0, 32'h404, 3'd2, 32'h0);
    xfer(1, 32'h400, 3'd2, 32'h0);
    xfer(1, 32'h000, 3'd2, 32'hDEADBEEF);
    xfer(1, 32'h404, 3'd2, 32'h77);
    xfer(0, 32'h000, 3'd2, 32'h0);
    xfer(0, 32'h404, 3'd2, 32'h0);
    uc_addr = 8'd12;
    xfer(1, 32'h400, 3'd2, 32'h1);
    xfer(1, 32'h030, 3'd2, 32'h11111111);
    xfer(1, 32'h400, 3'd2, 32'h0);
    xfer(1, 32'h034, 3'd2, 32'h22222222);
    xfer(1, 32'h400, 3'd2, 32'h1);
    xfer(0, 32'h030, 3'd2, 32'h0);
    xfer(0, 32'h034, 3'd2, 32'h0);
    xfer(1, 32'h400, 3'd2, 32'h0);
    xfer(1, 32'h405, 3'd0, 32'h0000FF00);
    xfer(1, 32'h406, 3'd1, 32'hFFFF0000);
    xfer(1, 32'h036, 3'd1, 32'h5A5A0000);
    xfer(0, 32'h034, 3'd2, 32'h0);
    xfer(1, 32'h500, 3'd2, 32'hFFFFFFFF);
    xfer(0, 32'h500, 3'd2, 32'h0);
    xfer(1, 32'h40C, 3'd2, 32'hFFFFFFFF);
    repeat (3) idle();
    xfer(1, 32'h404, 3'd2, 32'hF0);
    xfer(1, 32'h408, 3'd2, 32'h10);
    xfer(0, 32'h404, 3'd2, 32'h0);
    xfer(0, 32'h408, 3'd2, 32'h0);
    uc_hold = 1'b0;

    repeat (3000) begin
      if ($urandom_range(0, 9) == 0) idle();
      else begin
        sel  = $urandom_range(0, 9);
        size = 3'($urandom_range(0, 2));
        if (sel < 5)      addr = 32'($urandom_range(0, 'h3FF));
        else if (sel < 8) addr = 32'h400 + 32'(4 * $urandom_range(0, 3));
        else              addr = 32'($urandom_range('h410, 'hFFF));
        if (size == 3'd1) addr[0] = 1'b0;
        if (size == 3'd2) addr[1:0] = 2'b00;
        wd = $urandom;
        if (addr[11:0] == 12'h400) wd[0] = ($urandom_range(0, 2) == 0);
        xfer(1'($urandom_range(0, 1)), addr, size, wd);
      end
    end

    repeat (4) idle();
    chk("sb_drain", 32'(sbq.size()), 32'h0);
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
